xm_memory_responder: RTL



---
 rtl/xm_mem_pkg.sv | 18 +
 rtl/xm_mem_array.sv | 32 +++
 rtl/xm_memory_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/xm_mem_pkg.sv
// Shared types and constants for the X-Makina memory responder.
// Holds the FSM state encoding, byte-lane codes and the fault read value.
package xm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] LANE_NONE = 2'b00;
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_WORD = 2'b11;

    localparam logic [15:0] FAULT_RDATA = 16'hFFFF;

endpackage

// File: rtl/xm_mem_array.sv
// Single-port synchronous RAM, WORDS x 16, two byte write enables.
// Read data is registered and only changes when a read is enabled.
import xm_mem_pkg::*;

module xm_mem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic [1:0]    we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem [WORDS];

    // Byte-lane write and registered read share the single port.
    always_ff @(posedge clk_i) begin
        unique case (we_i)
            LANE_WORD: mem[addr_i] <= wdata_i;
            LANE_LO:   mem[addr_i][7:0] <= wdata_i[7:0];
            LANE_HI:   mem[addr_i][15:8] <= wdata_i[15:8];
            default: ;
        endcase
        if (re_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/xm_memory_responder.sv
// Wait-state memory responder for the X-Makina core memory port.
// Define XM_MEM_WRPROT_EN to reject writes below ROM_WORDS.
import xm_mem_pkg::*;

module xm_memory_responder #(
    parameter int WORD      = 16,
    parameter int ADDR_W    = 15,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2,
    parameter int ROM_WORDS = 64
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD-1:0]   wdata_i,
    input  logic [1:0]        datSel_i,
    output logic [WORD-1:0]   rdata_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              fault_o
);

    localparam int AW = $clog2(MEM_WORDS);

`ifdef XM_MEM_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              do_acc;
    logic              accept;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [WORD-1:0]   cap_wdata;
    logic [1:0]        cap_sel;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [WORD-1:0]   acc_wdata;
    logic [1:0]        acc_sel;
    logic              in_range;
    logic              wr_prot;

    logic [1:0]        ram_we;
    logic              ram_re;
    logic [15:0]       ram_rdata;

    logic              fault_q;
    logic              ram_vld_q;
    logic              oor_q;

    assign accept = req_i && (state_q != WAIT);

    // In WAIT the captured request is used; otherwise the live inputs
    // (only reached with zero wait states).
    assign acc_we    = (state_q == WAIT) ? cap_we    : we_i;
    assign acc_addr  = (state_q == WAIT) ? cap_addr  : addr_i;
    assign acc_wdata = (state_q == WAIT) ? cap_wdata : wdata_i;
    assign acc_sel   = (state_q == WAIT) ? cap_sel   : datSel_i;

    assign in_range = 32'(acc_addr) < MEM_WORDS;
    assign wr_prot  = WRPROT && acc_we && (32'(acc_addr) < ROM_WORDS);

    assign ram_we = (do_acc && acc_we && in_range && !wr_prot)
                  ? acc_sel : LANE_NONE;
    assign ram_re = do_acc && !acc_we && in_range;

    assign ready_o = (state_q == RESP);
    assign busy_o  = (state_q == WAIT);
    assign fault_o = ready_o && fault_q;
    assign rdata_o = oor_q     ? FAULT_RDATA :
                     ram_vld_q ? ram_rdata   : '0;

    // Next state, wait counter and access strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_acc  = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                if (req_i) begin
                    cnt_d = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        do_acc  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    do_acc  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request when it is accepted.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_sel   <= LANE_NONE;
        end else if (accept) begin
            cap_we    <= we_i;
            cap_addr  <= addr_i;
            cap_wdata <= wdata_i;
            cap_sel   <= datSel_i;
        end
    end

    // Record the access outcome and which source drives rdata_o.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            fault_q   <= 1'b0;
            ram_vld_q <= 1'b0;
            oor_q     <= 1'b0;
        end else if (do_acc) begin
            fault_q <= !in_range || wr_prot;
            if (!acc_we) begin
                ram_vld_q <= in_range;
                oor_q     <= !in_range;
            end
        end
    end

    xm_mem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (acc_addr[AW-1:0]),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

endmodule
